// File: rtl/mat_pkg.sv
// Shared definitions for the element-wise matrix ALU: operation codes,
// FSM state encoding and saturation bound helpers.
package mat_pkg;

   // Operation select codes
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_SCALE = 2'b10;
   localparam logic [1:0] OP_RSV   = 2'b11;

   // FSM state encoding
   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_CHECK   = 4'd1;
   localparam logic [3:0] ST_FETCH_A = 4'd2;
   localparam logic [3:0] ST_WAIT_A  = 4'd3;
   localparam logic [3:0] ST_FETCH_B = 4'd4;
   localparam logic [3:0] ST_WAIT_B  = 4'd5;
   localparam logic [3:0] ST_EMIT    = 4'd6;
   localparam logic [3:0] ST_DONE    = 4'd7;
   localparam logic [3:0] ST_ERR     = 4'd8;

   // Largest positive value of a dw-bit signed number (low dw bits valid)
   function automatic logic [31:0] sat_max_f(input int dw);
      return (32'h0000_0001 << (dw - 1)) - 32'h0000_0001;
   endfunction

   // Most negative value of a dw-bit signed number (low dw bits valid)
   function automatic logic [31:0] sat_min_f(input int dw);
      return 32'h0000_0001 << (dw - 1);
   endfunction

endpackage

// File: rtl/mat_elemwise_alu_if.sv
// Read-port and result-stream bundle of the element-wise matrix ALU.
// master: the ALU (issues reads, drives results); slave: store + sink.
interface mat_elemwise_alu_if #(
   parameter int DIM_WIDTH  = 3,
   parameter int DATA_WIDTH = 8,
   parameter int SLOT_WIDTH = 1
);
   logic                          rd_en;
   logic [SLOT_WIDTH-1:0]         rd_slot_idx;
   logic [DIM_WIDTH-1:0]          rd_row_idx;
   logic [DIM_WIDTH-1:0]          rd_col_idx;
   logic signed [DATA_WIDTH-1:0]  rd_elem;
   logic                          rd_elem_valid;

   logic                          out_valid;
   logic                          out_ready;
   logic signed [DATA_WIDTH-1:0]  out_elem;
   logic                          out_ovf;
   logic                          out_row_end;
   logic                          out_last;
   logic [2*DIM_WIDTH-1:0]        out_linear_idx;

   modport master (
      output rd_en, rd_slot_idx, rd_row_idx, rd_col_idx,
      input  rd_elem, rd_elem_valid,
      output out_valid, out_elem, out_ovf, out_row_end, out_last, out_linear_idx,
      input  out_ready
   );

   modport slave (
      input  rd_en, rd_slot_idx, rd_row_idx, rd_col_idx,
      output rd_elem, rd_elem_valid,
      input  out_valid, out_elem, out_ovf, out_row_end, out_last, out_linear_idx,
      output out_ready
   );
endinterface

// File: rtl/mat_elem_arith.sv
// Combinational element datapath: ADD/SUB at DATA_WIDTH+1, SCALE at
// 2*DATA_WIDTH, overflow detection and result narrowing.
// Build option MAT_ALU_SAT_EN: clamp overflowing results to the signed
// range limits; without it the low DATA_WIDTH bits are kept (wrap).
module mat_elem_arith
   import mat_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)(
   input  logic [1:0]                   op,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic signed [DATA_WIDTH-1:0] k,
   output logic signed [DATA_WIDTH-1:0] res,
   output logic                         ovf
);
   localparam int DW = DATA_WIDTH;

   logic signed [DW:0]     sum_s;
   logic signed [2*DW-1:0] a_ext_s;
   logic signed [2*DW-1:0] k_ext_s;
   logic signed [2*DW-1:0] prod_s;
   logic [DW-1:0]          wrap_s;
   logic                   neg_s;
`ifdef MAT_ALU_SAT_EN
   logic [31:0]            max_s;
   logic [31:0]            min_s;
`endif

   // Wide arithmetic, overflow flag and final (wrapped or clamped) result
   always_comb begin
      sum_s   = '0;
      a_ext_s = {{DW{a[DW-1]}}, a};
      k_ext_s = {{DW{k[DW-1]}}, k};
      prod_s  = '0;
      wrap_s  = '0;
      neg_s   = 1'b0;
      ovf     = 1'b0;
      case (op)
         OP_ADD: begin
            sum_s  = {a[DW-1], a} + {b[DW-1], b};
            wrap_s = sum_s[DW-1:0];
            neg_s  = sum_s[DW];
            ovf    = sum_s[DW] ^ sum_s[DW-1];
         end
         OP_SUB: begin
            sum_s  = {a[DW-1], a} - {b[DW-1], b};
            wrap_s = sum_s[DW-1:0];
            neg_s  = sum_s[DW];
            ovf    = sum_s[DW] ^ sum_s[DW-1];
         end
         OP_SCALE: begin
            prod_s = a_ext_s * k_ext_s;
            wrap_s = prod_s[DW-1:0];
            neg_s  = prod_s[2*DW-1];
            // in range only when the upper DW+1 bits are a pure sign extension
            ovf    = ~((&prod_s[2*DW-1:DW-1]) | (~|prod_s[2*DW-1:DW-1]));
         end
         default: begin
            wrap_s = '0;
            neg_s  = 1'b0;
            ovf    = 1'b0;
         end
      endcase
`ifdef MAT_ALU_SAT_EN
      max_s = sat_max_f(DW);
      min_s = sat_min_f(DW);
      if (ovf) begin
         if (neg_s) begin
            res = min_s[DW-1:0];
         end else begin
            res = max_s[DW-1:0];
         end
      end else begin
         res = wrap_s;
      end
`else
      res = wrap_s;
`endif
   end

endmodule

// File: rtl/mat_elemwise_alu.sv
// Element-wise matrix ALU: streams R = A op B (ADD/SUB) or R = A*k (SCALE)
// over an m x n matrix read one element at a time from the shared store.
// Build option MAT_ALU_SAT_EN selects saturating results (see mat_elem_arith).
module mat_elemwise_alu
   import mat_pkg::*;
#(
   parameter int DIM_WIDTH  = 3,
   parameter int DATA_WIDTH = 8,
   parameter int SLOT_WIDTH = 1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [1:0]                   op_sel,
   input  logic [DIM_WIDTH-1:0]         m_sel,
   input  logic [DIM_WIDTH-1:0]         n_sel,
   input  logic [SLOT_WIDTH-1:0]        slot_a_sel,
   input  logic                         slot_a_valid,
   input  logic [SLOT_WIDTH-1:0]        slot_b_sel,
   input  logic                         slot_b_valid,
   input  logic signed [DATA_WIDTH-1:0] scalar_k,
   output logic                         ready,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [2*DIM_WIDTH-1:0]       total_elements,
   mat_elemwise_alu_if.master           bus
);
   localparam int LW = 2 * DIM_WIDTH;
   localparam logic [DIM_WIDTH-1:0] DIM_ZERO = {DIM_WIDTH{1'b0}};
   localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0]        LIN_ONE  = {{(LW-1){1'b0}}, 1'b1};

   logic [3:0]                   state_r;
   logic [1:0]                   op_r;
   logic [DIM_WIDTH-1:0]         m_r;
   logic [DIM_WIDTH-1:0]         n_r;
   logic [SLOT_WIDTH-1:0]        slot_a_r;
   logic [SLOT_WIDTH-1:0]        slot_b_r;
   logic                         a_valid_r;
   logic                         b_valid_r;
   logic signed [DATA_WIDTH-1:0] k_r;
   logic signed [DATA_WIDTH-1:0] a_r;
   logic [DIM_WIDTH-1:0]         row_r;
   logic [DIM_WIDTH-1:0]         col_r;
   logic [LW-1:0]                lin_r;
   logic [LW-1:0]                total_r;
   logic                         ready_r;
   logic                         busy_r;
   logic                         done_r;
   logic                         error_r;
   logic                         rd_en_r;
   logic [SLOT_WIDTH-1:0]        rd_slot_r;
   logic                         out_valid_r;
   logic signed [DATA_WIDTH-1:0] out_elem_r;
   logic                         out_ovf_r;
   logic                         out_row_end_r;
   logic                         out_last_r;
   logic [LW-1:0]                out_lin_r;

   logic                         check_fail_s;
   logic                         capture_s;
   logic                         col_last_s;
   logic                         row_last_s;
   logic                         abort_hit_s;
   logic signed [DATA_WIDTH-1:0] arith_a_s;
   logic signed [DATA_WIDTH-1:0] res_s;
   logic                         ovf_s;

   assign ready             = ready_r;
   assign busy              = busy_r;
   assign done              = done_r;
   assign error             = error_r;
   assign total_elements    = total_r;
   assign bus.rd_en         = rd_en_r;
   assign bus.rd_slot_idx   = rd_slot_r;
   assign bus.rd_row_idx    = row_r;
   assign bus.rd_col_idx    = col_r;
   assign bus.out_valid     = out_valid_r;
   assign bus.out_elem      = out_elem_r;
   assign bus.out_ovf       = out_ovf_r;
   assign bus.out_row_end   = out_row_end_r;
   assign bus.out_last      = out_last_r;
   assign bus.out_linear_idx = out_lin_r;

   mat_elem_arith #(.DATA_WIDTH(DATA_WIDTH)) u_arith (
      .op  (op_r),
      .a   (arith_a_s),
      .b   (bus.rd_elem),
      .k   (k_r),
      .res (res_s),
      .ovf (ovf_s)
   );

   // Position flags and operand validation for the latched request
   always_comb begin
      col_last_s   = (col_r == (n_r - DIM_ONE));
      row_last_s   = (row_r == (m_r - DIM_ONE));
      check_fail_s = 1'b0;
      if ((m_r == DIM_ZERO) || (n_r == DIM_ZERO) || (op_r == OP_RSV) || !a_valid_r ||
          ((op_r != OP_SCALE) && !b_valid_r)) begin
         check_fail_s = 1'b1;
      end else begin
         check_fail_s = 1'b0;
      end
   end

   // Operand A comes straight from the store during WAIT_A (SCALE), else from its latch
   always_comb begin
      arith_a_s = a_r;
      if (state_r == ST_WAIT_A) begin
         arith_a_s = bus.rd_elem;
      end else begin
         arith_a_s = a_r;
      end
   end

   // A result is ready when the last operand of the element arrives
   always_comb begin
      capture_s   = 1'b0;
      abort_hit_s = 1'b0;
      if ((state_r == ST_WAIT_B) && bus.rd_elem_valid) begin
         capture_s = 1'b1;
      end else if ((state_r == ST_WAIT_A) && bus.rd_elem_valid && (op_r == OP_SCALE)) begin
         capture_s = 1'b1;
      end else begin
         capture_s = 1'b0;
      end
      // DONE/ERR already carry their terminal pulse, so abort has nothing left to cancel
      if (abort && (state_r != ST_IDLE) && (state_r != ST_DONE) && (state_r != ST_ERR)) begin
         abort_hit_s = 1'b1;
      end else begin
         abort_hit_s = 1'b0;
      end
   end

   // Control FSM: request latching, read sequencing, handshake and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         op_r        <= 2'b00;
         m_r         <= DIM_ZERO;
         n_r         <= DIM_ZERO;
         slot_a_r    <= '0;
         slot_b_r    <= '0;
         a_valid_r   <= 1'b0;
         b_valid_r   <= 1'b0;
         k_r         <= '0;
         a_r         <= '0;
         row_r       <= DIM_ZERO;
         col_r       <= DIM_ZERO;
         lin_r       <= '0;
         total_r     <= '0;
         ready_r     <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         rd_en_r     <= 1'b0;
         rd_slot_r   <= '0;
         out_valid_r <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         error_r <= 1'b0;
         rd_en_r <= 1'b0;
         if (abort_hit_s) begin
            state_r     <= ST_ERR;
            error_r     <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start && ready_r) begin
                     op_r      <= op_sel;
                     m_r       <= m_sel;
                     n_r       <= n_sel;
                     slot_a_r  <= slot_a_sel;
                     slot_b_r  <= slot_b_sel;
                     a_valid_r <= slot_a_valid;
                     b_valid_r <= slot_b_valid;
                     k_r       <= scalar_k;
                     total_r   <= {{DIM_WIDTH{1'b0}}, m_sel} * {{DIM_WIDTH{1'b0}}, n_sel};
                     row_r     <= DIM_ZERO;
                     col_r     <= DIM_ZERO;
                     lin_r     <= '0;
                     busy_r    <= 1'b1;
                     ready_r   <= 1'b0;
                     state_r   <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  if (check_fail_s) begin
                     state_r <= ST_ERR;
                     error_r <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r   <= ST_FETCH_A;
                     rd_en_r   <= 1'b1;
                     rd_slot_r <= slot_a_r;
                  end
               end
               ST_FETCH_A: begin
                  state_r <= ST_WAIT_A;
               end
               ST_WAIT_A: begin
                  if (bus.rd_elem_valid) begin
                     a_r <= bus.rd_elem;
                     if (op_r == OP_SCALE) begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_EMIT;
                     end else begin
                        rd_en_r   <= 1'b1;
                        rd_slot_r <= slot_b_r;
                        state_r   <= ST_FETCH_B;
                     end
                  end
               end
               ST_FETCH_B: begin
                  state_r <= ST_WAIT_B;
               end
               ST_WAIT_B: begin
                  if (bus.rd_elem_valid) begin
                     out_valid_r <= 1'b1;
                     state_r     <= ST_EMIT;
                  end
               end
               ST_EMIT: begin
                  if (bus.out_ready) begin
                     out_valid_r <= 1'b0;
                     if (col_last_s && row_last_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                     end else begin
                        if (col_last_s) begin
                           col_r <= DIM_ZERO;
                           row_r <= row_r + DIM_ONE;
                        end else begin
                           col_r <= col_r + DIM_ONE;
                        end
                        lin_r     <= lin_r + LIN_ONE;
                        rd_en_r   <= 1'b1;
                        rd_slot_r <= slot_a_r;
                        state_r   <= ST_FETCH_A;
                     end
                  end
               end
               ST_DONE, ST_ERR: begin
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
               default: begin
                  ready_r     <= 1'b1;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Result register: element value and its position tags, held through EMIT
   always_ff @(posedge clk) begin
      if (rst) begin
         out_elem_r    <= '0;
         out_ovf_r     <= 1'b0;
         out_row_end_r <= 1'b0;
         out_last_r    <= 1'b0;
         out_lin_r     <= '0;
      end else if (capture_s) begin
         out_elem_r    <= res_s;
         out_ovf_r     <= ovf_s;
         out_row_end_r <= col_last_s;
         out_last_r    <= col_last_s && row_last_s;
         out_lin_r     <= lin_r;
      end
   end

endmodule

// File: tb/tb_mat_elemwise_alu.sv
// Directed self-checking bench for mat_elemwise_alu (wrap or MAT_ALU_SAT_EN build).
module tb_mat_elemwise_alu;
   localparam logic [1:0] T_ADD = 2'b00;
   localparam logic [1:0] T_SUB = 2'b01;
   localparam logic [1:0] T_SCL = 2'b10;
   localparam logic [1:0] T_RSV = 2'b11;
`ifdef MAT_ALU_SAT_EN
   localparam logic [7:0] EXP_SUB_OVF = 8'h80;
   localparam logic [7:0] EXP_SCL_POS = 8'h7F;
   localparam logic [7:0] EXP_SCL_NEG = 8'h80;
`else
   localparam logic [7:0] EXP_SUB_OVF = 8'h7F;
   localparam logic [7:0] EXP_SCL_POS = 8'h96;
   localparam logic [7:0] EXP_SCL_NEG = 8'h6A;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] op_sel = 2'b00;
   logic [2:0] m_sel = 3'd0;
   logic [2:0] n_sel = 3'd0;
   logic       slot_a_sel = 1'b0;
   logic       slot_a_valid = 1'b0;
   logic       slot_b_sel = 1'b0;
   logic       slot_b_valid = 1'b0;
   logic [7:0] scalar_k = 8'd0;
   logic       ready, busy, done, error;
   logic [5:0] total_elements;

   mat_elemwise_alu_if #(.DIM_WIDTH(3), .DATA_WIDTH(8), .SLOT_WIDTH(1)) bus ();

   mat_elemwise_alu #(.DIM_WIDTH(3), .DATA_WIDTH(8), .SLOT_WIDTH(1)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .op_sel(op_sel),
      .m_sel(m_sel), .n_sel(n_sel), .slot_a_sel(slot_a_sel), .slot_a_valid(slot_a_valid),
      .slot_b_sel(slot_b_sel), .slot_b_valid(slot_b_valid), .scalar_k(scalar_k),
      .ready(ready), .busy(busy), .done(done), .error(error),
      .total_elements(total_elements), .bus(bus)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int pass_cnt = 0;

   logic [7:0] mem [0:1][0:7][0:7];
   int   resp_delay = 0;
   int   pend_cnt = 0;
   logic rq_slot = 1'b0;
   logic [2:0] rq_row = 3'd0;
   logic [2:0] rq_col = 3'd0;
   int   rd_cnt0 = 0;
   int   rd_cnt1 = 0;
   int   rd_total = 0;

   logic [7:0] got_elem [0:15];
   logic       got_ovf  [0:15];
   logic       got_re   [0:15];
   logic       got_last [0:15];
   logic [5:0] got_idx  [0:15];
   int         n_got, n_done, n_err;
   bit         timed_out;

   // Store model: answers each read 1+resp_delay cycles later with a 1-cycle valid
   initial begin
      bus.rd_elem = 8'd0;
      bus.rd_elem_valid = 1'b0;
      forever begin
         @(negedge clk);
         bus.rd_elem_valid = 1'b0;
         if (rst) begin
            pend_cnt = 0;
         end else if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               bus.rd_elem_valid = 1'b1;
               bus.rd_elem = mem[rq_slot][rq_row][rq_col];
            end
         end
         if (bus.rd_en === 1'b1) begin
            rd_total++;
            if (bus.rd_slot_idx == 1'b1) rd_cnt1++; else rd_cnt0++;
            rq_slot = bus.rd_slot_idx;
            rq_row  = bus.rd_row_idx;
            rq_col  = bus.rd_col_idx;
            pend_cnt = 1 + resp_delay;
         end
      end
   end

   // Called at a negedge: presents a one-cycle start request
   task automatic do_start(input logic [1:0] op, input logic [2:0] m, input logic [2:0] n,
                           input logic sa, input logic sav, input logic sb, input logic sbv,
                           input logic [7:0] k);
      op_sel = op; m_sel = m; n_sel = n; slot_a_sel = sa; slot_a_valid = sav;
      slot_b_sel = sb; slot_b_valid = sbv; scalar_k = k; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Records every handshake until done/error or the cycle budget runs out
   task automatic collect(input int max_cycles);
      n_got = 0; n_done = 0; n_err = 0; timed_out = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready && n_got < 16) begin
            got_elem[n_got] = bus.out_elem; got_ovf[n_got] = bus.out_ovf;
            got_re[n_got] = bus.out_row_end; got_last[n_got] = bus.out_last;
            got_idx[n_got] = bus.out_linear_idx; n_got++;
         end
         if (done) n_done++;
         if (error) n_err++;
         if (done || error) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic load_add();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 3; c++) begin
            mem[0][r][c] = 8'(r * 3 + c + 1);
            mem[1][r][c] = 8'(10 * (r * 3 + c + 1));
         end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++; if (ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", ready); else pass_cnt++;
      chk_cnt++; if ({busy, done, error, bus.rd_en, bus.out_valid} !== 5'b0)
         $display("FAIL rst_flags got %b exp 00000", {busy, done, error, bus.rd_en, bus.out_valid}); else pass_cnt++;
      chk_cnt++; if (total_elements !== 6'd0) $display("FAIL rst_total got %0d exp 0", total_elements); else pass_cnt++;
      chk_cnt++; if ({bus.out_elem, bus.out_linear_idx} !== 14'd0)
         $display("FAIL rst_out got %h exp 0", {bus.out_elem, bus.out_linear_idx}); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++; if (ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", ready); else pass_cnt++;
   endtask

   task automatic test_add();
      int b0, b1;
      load_add();
      bus.out_ready = 1'b1;
      b0 = rd_cnt0; b1 = rd_cnt1;
      do_start(T_ADD, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      collect(300);
      chk_cnt++; if (timed_out) $display("FAIL add_timeout got 1 exp 0"); else pass_cnt++;
      chk_cnt++; if (n_got !== 6) $display("FAIL add_count got %0d exp 6", n_got); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++;
         if ({got_elem[i], got_ovf[i], got_re[i], got_last[i], got_idx[i]} !==
             {8'(11 * (i + 1)), 1'b0, (i == 2 || i == 5), (i == 5), 6'(i)})
            $display("FAIL add_elem%0d got %0d ovf%b re%b last%b idx%0d exp %0d", i, got_elem[i],
                     got_ovf[i], got_re[i], got_last[i], got_idx[i], 11 * (i + 1));
         else pass_cnt++;
      end
      chk_cnt++; if (n_done !== 1 || n_err !== 0) $display("FAIL add_done got %0d/%0d exp 1/0", n_done, n_err); else pass_cnt++;
      chk_cnt++; if (total_elements !== 6'd6) $display("FAIL add_total got %0d exp 6", total_elements); else pass_cnt++;
      chk_cnt++; if (rd_cnt0 - b0 !== 6 || rd_cnt1 - b1 !== 6)
         $display("FAIL add_reads got %0d/%0d exp 6/6", rd_cnt0 - b0, rd_cnt1 - b1); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL add_ready got %b%b exp 10", ready, done); else pass_cnt++;
   endtask

   task automatic test_sub_ovf();
      mem[0][0][0] = 8'h80; mem[1][0][0] = 8'h01;
      do_start(T_SUB, 3'd1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      collect(100);
      chk_cnt++; if (n_got !== 1 || n_done !== 1) $display("FAIL sub_count got %0d/%0d exp 1/1", n_got, n_done); else pass_cnt++;
      chk_cnt++; if ({got_elem[0], got_ovf[0], got_re[0], got_last[0]} !== {EXP_SUB_OVF, 3'b111})
         $display("FAIL sub_ovf got %h ovf%b exp %h ovf1", got_elem[0], got_ovf[0], EXP_SUB_OVF); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_scale();
      logic [7:0] exp_e [0:3];
      logic       exp_o [0:3];
      int b0, b1;
      exp_e[0] = 8'd30; exp_e[1] = EXP_SCL_POS; exp_e[2] = EXP_SCL_NEG; exp_e[3] = 8'd6;
      exp_o[0] = 1'b0;  exp_o[1] = 1'b1;        exp_o[2] = 1'b1;        exp_o[3] = 1'b0;
      mem[0][0][0] = 8'd10; mem[0][0][1] = 8'd50; mem[0][1][0] = 8'hCE; mem[0][1][1] = 8'd2;
      resp_delay = 2;
      b0 = rd_cnt0; b1 = rd_cnt1;
      do_start(T_SCL, 3'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
      collect(300);
      resp_delay = 0;
      chk_cnt++; if (n_got !== 4 || n_done !== 1) $display("FAIL scl_count got %0d/%0d exp 4/1", n_got, n_done); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if ({got_elem[i], got_ovf[i], got_idx[i]} !== {exp_e[i], exp_o[i], 6'(i)})
            $display("FAIL scl_elem%0d got %h ovf%b idx%0d exp %h ovf%b", i, got_elem[i], got_ovf[i],
                     got_idx[i], exp_e[i], exp_o[i]);
         else pass_cnt++;
      end
      chk_cnt++; if (rd_cnt1 - b1 !== 0 || rd_cnt0 - b0 !== 4)
         $display("FAIL scl_reads got a%0d b%0d exp a4 b0", rd_cnt0 - b0, rd_cnt1 - b1); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit stalled, bad, fin;
      int base;
      load_add();
      bus.out_ready = 1'b1;
      stalled = 1'b0; bad = 1'b0; fin = 1'b0; base = 0; n_got = 0;
      do_start(T_ADD, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         if (!stalled && bus.out_valid && bus.out_linear_idx == 6'd2) begin
            stalled = 1'b1;
            bus.out_ready = 1'b0;
            base = rd_total;
            repeat (5) begin
               @(negedge clk);
               if ({bus.out_valid, bus.out_elem, bus.out_linear_idx, bus.out_row_end, bus.out_last, bus.rd_en}
                   !== {1'b1, 8'd33, 6'd2, 1'b1, 1'b0, 1'b0}) bad = 1'b1;
            end
            chk_cnt++; if (rd_total !== base) $display("FAIL bp_no_read got %0d exp %0d", rd_total, base); else pass_cnt++;
            bus.out_ready = 1'b1;
         end
         if (bus.out_valid && bus.out_ready && n_got < 16) begin
            got_elem[n_got] = bus.out_elem; n_got++;
         end
         if (done) fin = 1'b1;
      end
      chk_cnt++; if (stalled !== 1'b1 || bad !== 1'b0) $display("FAIL bp_stable got stall%b bad%b exp 1 0", stalled, bad); else pass_cnt++;
      chk_cnt++; if (n_got !== 6 || fin !== 1'b1) $display("FAIL bp_count got %0d done%b exp 6 1", n_got, fin); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         chk_cnt++; if (got_elem[i] !== 8'(11 * (i + 1)))
            $display("FAIL bp_elem%0d got %0d exp %0d", i, got_elem[i], 11 * (i + 1)); else pass_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic test_errors();
      logic [1:0] cop [0:2];
      logic [2:0] cm  [0:2];
      logic       cbv [0:2];
      int base;
      cop[0] = T_ADD; cm[0] = 3'd0; cbv[0] = 1'b1;
      cop[1] = T_RSV; cm[1] = 3'd2; cbv[1] = 1'b1;
      cop[2] = T_ADD; cm[2] = 3'd1; cbv[2] = 1'b0;
      for (int t = 0; t < 3; t++) begin
         base = rd_total;
         do_start(cop[t], cm[t], 3'd2, 1'b0, 1'b1, 1'b1, cbv[t], 8'd0);
         chk_cnt++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL err%0d_early got e%b b%b exp e0 b1", t, error, busy); else pass_cnt++;
         @(negedge clk);
         chk_cnt++; if (error !== 1'b1 || done !== 1'b0 || ready !== 1'b0)
            $display("FAIL err%0d_pulse got e%b d%b r%b exp 1 0 0", t, error, done, ready); else pass_cnt++;
         @(negedge clk);
         chk_cnt++; if (error !== 1'b0 || ready !== 1'b1 || rd_total !== base)
            $display("FAIL err%0d_after got e%b r%b reads %0d exp 0 1 %0d", t, error, ready, rd_total, base); else pass_cnt++;
      end
   endtask

   task automatic test_abort();
      bit found, saw;
      found = 1'b0; saw = 1'b0;
      mem[0][0][0] = 8'd5; mem[1][0][0] = 8'd7; mem[0][0][1] = 8'd1; mem[1][0][1] = 8'd2;
      resp_delay = 4;
      do_start(T_ADD, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (bus.rd_en && bus.rd_slot_idx == 1'b1) found = 1'b1;
      end
      chk_cnt++; if (!found) $display("FAIL abort_reach got 0 exp 1"); else pass_cnt++;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_cnt++; if ({error, done, bus.out_valid} !== 3'b100)
         $display("FAIL abort_pulse got %b exp 100", {error, done, bus.out_valid}); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if ({ready, busy, error} !== 3'b100) $display("FAIL abort_idle got %b exp 100", {ready, busy, error}); else pass_cnt++;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid || done || error) saw = 1'b1;
      end
      chk_cnt++; if (saw) $display("FAIL abort_quiet got 1 exp 0"); else pass_cnt++;
      resp_delay = 0;
   endtask

   task automatic test_rst_mid_emit();
      bit found;
      found = 1'b0;
      load_add();
      bus.out_ready = 1'b0;
      do_start(T_ADD, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (bus.out_valid) found = 1'b1;
      end
      chk_cnt++; if (!found || bus.out_elem !== 8'd11) $display("FAIL rst_emit_reach got %b %0d exp 1 11", found, bus.out_elem); else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      chk_cnt++; if ({ready, busy, done, error, bus.rd_en, bus.out_valid} !== 6'b100000)
         $display("FAIL rst_emit_flags got %b exp 100000", {ready, busy, done, error, bus.rd_en, bus.out_valid}); else pass_cnt++;
      chk_cnt++; if ({total_elements, bus.out_elem, bus.out_linear_idx, bus.out_last} !== 21'd0)
         $display("FAIL rst_emit_data got %h exp 0", {total_elements, bus.out_elem, bus.out_linear_idx, bus.out_last}); else pass_cnt++;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      load_add();
      bus.out_ready = 1'b1;
      do_start(T_ADD, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      // a second request while busy must be ignored
      op_sel = T_SCL; m_sel = 3'd3; n_sel = 3'd3; scalar_k = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect(200);
      chk_cnt++; if (n_got !== 2 || n_done !== 1 || total_elements !== 6'd2)
         $display("FAIL b2b_first got n%0d d%0d t%0d exp 2 1 2", n_got, n_done, total_elements); else pass_cnt++;
      chk_cnt++; if ({got_elem[0], got_elem[1], got_last[1]} !== {8'd11, 8'd22, 1'b1})
         $display("FAIL b2b_first_data got %0d %0d exp 11 22", got_elem[0], got_elem[1]); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ready); else pass_cnt++;
      do_start(T_SUB, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
      collect(200);
      chk_cnt++; if (n_got !== 2 || {got_elem[0], got_elem[1]} !== {8'd9, 8'd18} || n_done !== 1)
         $display("FAIL b2b_second got n%0d %0d %0d exp 2 9 18", n_got, got_elem[0], got_elem[1]); else pass_cnt++;
      @(negedge clk);
   endtask

   initial begin
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
               mem[s][r][c] = 8'd0;
      bus.out_ready = 1'b1;
      test_reset();
      test_add();
      test_sub_ovf();
      test_scale();
      test_backpressure();
      test_errors();
      test_abort();
      test_rst_mid_emit();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
